spi_cmd_arbiter: RTL

Shares one SPI master (4-line, event-pulse command interface) between NREQ independent requesters. Grants are round-robin. The block sequences exactly one read or write transaction at a time into the master, waits for completion or timeout, and returns a response to the granted requester. It sits between the register-access clients and the SPI master, which runs on the same clock and reset.

---
 rtl/spi_arb_pkg.sv | 21 ++
 rtl/spi_rr_arbiter.sv | 39 +++
 rtl/spi_cmd_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/spi_arb_pkg.sv
// Shared types and helpers for the SPI command arbiter: one-hot FSM states
// and a width helper for pointer, grant and counter vectors.
package spi_arb_pkg;

  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    ISSUE = 5'b00010,
    WAIT  = 5'b00100,
    RESP  = 5'b01000,
    GAP   = 5'b10000
  } state_t;

  // Never returns less than 1 so single-entry ranges still get a real vector.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// Combinational rotate-priority arbiter: searches upward from ptr, wrapping,
// and returns the first active request as one-hot grant plus its index.
module spi_rr_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int PW   = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   grant_idx,
  output logic            grant_any
);

  logic [PW:0]   sum;
  logic [PW-1:0] idx;

  // Walk from the farthest offset down so the nearest hit to ptr wins last.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      sum = {1'b0, ptr} + (PW + 1)'(i);
      if (sum >= (PW + 1)'(NREQ)) sum = sum - (PW + 1)'(NREQ);
      idx = sum[PW-1:0];
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = idx;
        grant_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_cmd_arbiter.sv
// Round-robin sharing of one SPI master between NREQ register-access clients;
// one transaction in flight, with timeout and an enforced idle gap.
module spi_cmd_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NREQ           = 4,
  parameter int AWIDTH         = 16,
  parameter int DWIDTH         = 8,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int GAP_CYCLES     = 4
) (
  input  logic                     user_clk,
  input  logic                     user_rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_rw,
  input  logic [NREQ*AWIDTH-1:0]   req_addr,
  input  logic [NREQ*DWIDTH-1:0]   req_wdata,
  output logic [NREQ-1:0]          req_ready,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [DWIDTH-1:0]        rsp_rdata,
  output logic                     rsp_err,
  output logic                     m_rd_evt,
  output logic                     m_wr_evt,
  output logic [AWIDTH-1:0]        m_addr,
  output logic [DWIDTH-1:0]        m_wr_data,
  input  logic                     m_done_evt,
  input  logic                     m_rd_data_evt,
  input  logic [DWIDTH-1:0]        m_rd_data,
  output logic                     busy
);

  localparam int PW = clog2(NREQ);
  localparam int TW = clog2(TIMEOUT_CYCLES);
  localparam int GW = clog2(GAP_CYCLES);

  state_t              state_reg, state_next;
  logic [PW-1:0]       ptr_reg;
  logic [NREQ-1:0]     gnt_reg;
  logic                rw_reg;
  logic [AWIDTH-1:0]   addr_reg;
  logic [DWIDTH-1:0]   wdata_reg;
  logic [DWIDTH-1:0]   rdata_reg;
  logic                cmpl_reg;
  logic                err_reg;
  logic [TW-1:0]       tmo_cnt_reg;
  logic [GW-1:0]       gap_cnt_reg;

  logic [AWIDTH-1:0]   addr_arr  [NREQ];
  logic [DWIDTH-1:0]   wdata_arr [NREQ];
  logic [NREQ-1:0]     grant;
  logic [PW-1:0]       grant_idx;
  logic                grant_any;
  logic                evt;
  logic                tmo_hit;
  logic                gap_last;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
    assign addr_arr[gi]  = req_addr[gi*AWIDTH +: AWIDTH];
    assign wdata_arr[gi] = req_wdata[gi*DWIDTH +: DWIDTH];
  end

  spi_rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr (
    .req       (req_valid),
    .ptr       (ptr_reg),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // A read finishes on the data pulse, not on done, which precedes it.
  assign evt      = rw_reg ? m_rd_data_evt : m_done_evt;
  assign tmo_hit  = (tmo_cnt_reg == TW'(TIMEOUT_CYCLES - 1));
  assign gap_last = (gap_cnt_reg == GW'(GAP_CYCLES - 1));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant_any) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT: begin
        if (cmpl_reg)              state_next = RESP;
        else if (!evt && tmo_hit)  state_next = RESP;
      end
      RESP:    state_next = GAP;
      GAP:     if (gap_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      state_reg   <= IDLE;
      ptr_reg     <= '0;
      gnt_reg     <= '0;
      rw_reg      <= 1'b0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      rdata_reg   <= '0;
      cmpl_reg    <= 1'b0;
      err_reg     <= 1'b0;
      tmo_cnt_reg <= '0;
      gap_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (grant_any) begin
            gnt_reg   <= grant;
            rw_reg    <= req_rw[grant_idx];
            addr_reg  <= addr_arr[grant_idx];
            wdata_reg <= wdata_arr[grant_idx];
            ptr_reg   <= (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
          end
        end
        ISSUE: begin
          tmo_cnt_reg <= '0;
          cmpl_reg    <= 1'b0;
          err_reg     <= 1'b0;
          rdata_reg   <= '0;
        end
        WAIT: begin
          tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
          // Completion is registered here; RESP follows one cycle later.
          if (!cmpl_reg && evt) begin
            cmpl_reg <= 1'b1;
            if (rw_reg) rdata_reg <= m_rd_data;
          end else if (!cmpl_reg && tmo_hit) begin
            err_reg   <= 1'b1;
            rdata_reg <= '0;
          end
        end
        RESP:    gap_cnt_reg <= '0;
        GAP:     gap_cnt_reg <= gap_cnt_reg + 1'b1;
        default: ;
      endcase
    end
  end

  assign req_ready = (state_reg == ISSUE) ? gnt_reg : '0;
  assign m_rd_evt  = (state_reg == ISSUE) &&  rw_reg;
  assign m_wr_evt  = (state_reg == ISSUE) && !rw_reg;
  assign rsp_valid = (state_reg == RESP) ? gnt_reg : '0;
  assign rsp_err   = (state_reg == RESP) && err_reg;
  assign rsp_rdata = rdata_reg;
  assign m_addr    = addr_reg;
  assign m_wr_data = wdata_reg;
  assign busy      = (state_reg != IDLE);

endmodule
